mem_rst_rsp: RTL and testbench
==============================

Name: mem_rst_rsp

Overview:
- Responder side of the memory-subsystem warm-reset handshake.
- Sits directly downstream of the reset-handshake initiator. Consumes its rst_req/rst_n and returns rst_rdy/rst_ack_n.
- Quiesces the memory request path by blocking new commands and draining outstanding ones, then applies a local warm reset to the memory controller.
- Signals completion only after the controller recalibrates.

Parameters:
- CNT_W, 8, width of the outstanding-transaction counter.
- DRAIN_TIMEOUT, 4096, maximum DRAIN cycles before forced progress; must be ≥1.
- RST_HOLD, 16, cycles core_rst_n is held low before acknowledging; must be ≥1.

Ports:
- clk  in  1  subsystem clock.
- rst_n  in  1  asynchronous active-low reset.
- hs_rst_req  in  1  reset request from initiator.
- hs_rst_n  in  1  warm reset from initiator, active low.
- hs_rst_rdy  out  1  responder quiesced and ready for reset.
- hs_rst_ack_n  out  1  low = reset applied; high = idle/recovered.
- cmd_issue  in  1  one memory command accepted this cycle.
- rsp_done  in  1  one memory command completed this cycle.
- block_new  out  1  upstream must stop issuing commands while high.
- core_rst_n  out  1  local warm reset to memory controller, active low.
- cal_done  in  1  controller calibration complete.
- drain_timeout  out  1  sticky: DRAIN exited via timeout.
- proto_err  out  1  sticky: counter over/underflow, or hs_rst_n low outside READY.

Behaviour:
- Reset values: state=RUN, hs_rst_rdy=0, hs_rst_ack_n=1, block_new=0, core_rst_n=1, outstanding=0, both sticky flags=0.
- All outputs are registered.
- Outstanding counter is updated every cycle in every state:
  - issue only: +1. done only: −1. Both together: unchanged.
  - Increment at all-ones: saturates and sets proto_err.
  - Decrement at 0: holds 0 and sets proto_err.
- RUN:
  - On hs_rst_req=1: next cycle state=DRAIN, block_new=1, drain timer cleared.
- DRAIN:
  - Drain timer increments each cycle.
  - When outstanding==0 (after this cycle's update): next cycle state=READY, hs_rst_rdy=1.
  - Else when timer reaches DRAIN_TIMEOUT−1: same transition, plus drain_timeout=1.
  - hs_rst_req dropping in DRAIN is ignored.
- READY:
  - hs_rst_rdy=1, hold until hs_rst_n=0.
  - Then next cycle: state=IN_RST, hs_rst_rdy=0, core_rst_n=0, hold timer cleared.
- IN_RST:
  - Hold timer increments.
  - After core_rst_n has been low for RST_HOLD cycles: hs_rst_ack_n=0, state=ACKED.
- ACKED:
  - core_rst_n stays 0.
  - On hs_rst_n=1: next cycle core_rst_n=1, state=RECOVER.
- RECOVER:
  - hs_rst_ack_n stays 0 and block_new stays 1.
  - On cal_done=1: next cycle hs_rst_ack_n=1, block_new=0, state=RUN.
  - cal_done already high on entry still requires one cycle in RECOVER.
- hs_rst_n=0 in RUN or DRAIN:
  - Protocol violation; set proto_err.
  - Go directly to IN_RST with block_new=1 and hs_rst_rdy=0.
- Outstanding counter is forced to 0 on entry to IN_RST; completions from the reset controller are not expected.
- Counter updates in IN_RST/ACKED/RECOVER still apply the over/underflow rules.
- hs_rst_req=1 in RUN coinciding with cmd_issue=1: the command counts; block_new rises next cycle.
- A new request is accepted only in RUN, so hs_rst_ack_n is always high when a request is accepted.
- Asynchronous rst_n assertion mid-sequence forces all reset values immediately, including core_rst_n=1 and block_new=0.
- Sticky flags clear only on rst_n.
- Latency with no outstanding commands, req to rdy: 2 cycles (RUN→DRAIN, DRAIN→READY).

Test Plan:
- Idle handshake: outstanding=0, hs_rst_req=1 at cycle 0.
  - → hs_rst_rdy=1 at cycle 2.
  - hs_rst_n=0 at cycle 4 → core_rst_n=0 at cycle 5, hs_rst_ack_n=0 at cycle 5+RST_HOLD.
  - hs_rst_n=1 → core_rst_n=1 next cycle.
  - cal_done → hs_rst_ack_n=1, block_new=0, state RUN.
- Drain with traffic: 5 cmd_issue before req; 3 rsp_done at 10-cycle spacing after req, then cmd_issue and rsp_done together, then 2 more rsp_done.
  - → hs_rst_rdy only after the last rsp_done.
  - drain_timeout=0; block_new=1 throughout.
- Timeout: DRAIN_TIMEOUT=32, 1 outstanding never completed.
  - → hs_rst_rdy=1 exactly 32 cycles after DRAIN entry.
  - drain_timeout=1; counter forced 0 at IN_RST.
- Errors:
  - rsp_done with outstanding=0 → proto_err=1, counter stays 0.
  - Separately, hs_rst_n=0 while in RUN → IN_RST next cycle, proto_err=1.
- Mid-sequence reset: assert rst_n=0 during ACKED.
  - → immediately core_rst_n=1, hs_rst_ack_n=1, hs_rst_rdy=0, block_new=0.
  - After release, a fresh hs_rst_req completes a normal sequence.
- Counter saturation: CNT_W=2, 4 issues with no completions.
  - → counter=3, proto_err=1.
  - 3 completions reach 0; rdy asserts in DRAIN.

Source files
------------

// File: rtl/mem_rst_rsp_if.sv
// Signal bundle between the warm-reset initiator/memory front end and the
// mem_rst_rsp responder.
interface mem_rst_rsp_if;
    logic hs_rst_req;
    logic hs_rst_n;
    logic hs_rst_rdy;
    logic hs_rst_ack_n;
    logic cmd_issue;
    logic rsp_done;
    logic block_new;
    logic core_rst_n;
    logic cal_done;
    logic drain_timeout;
    logic proto_err;

    modport master (
        output hs_rst_req, hs_rst_n, cmd_issue, rsp_done, cal_done,
        input  hs_rst_rdy, hs_rst_ack_n, block_new, core_rst_n,
               drain_timeout, proto_err
    );

    modport slave (
        input  hs_rst_req, hs_rst_n, cmd_issue, rsp_done, cal_done,
        output hs_rst_rdy, hs_rst_ack_n, block_new, core_rst_n,
               drain_timeout, proto_err
    );
endinterface

// File: rtl/mem_rst_rsp.sv
// Warm-reset responder: blocks and drains memory traffic, then holds the
// controller in reset and acknowledges once it has recalibrated.
module mem_rst_rsp #(
    parameter int CNT_W         = 8,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int RST_HOLD      = 16
) (
    input logic           clk,
    input logic           rst_n,
    mem_rst_rsp_if.slave  bus
);

    localparam int DT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int HT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        READY,
        IN_RST,
        ACKED,
        RECOVER
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_upd;
    logic             cnt_err;
    logic [DT_W-1:0]  drain_tmr_q, drain_tmr_d;
    logic [HT_W-1:0]  hold_tmr_q, hold_tmr_d;
    logic             rdy_q, rdy_d;
    logic             ack_n_q, ack_n_d;
    logic             block_q, block_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             drain_to_q, drain_to_d;
    logic             proto_err_q, proto_err_d;
    logic             enter_rst;

    // Saturating outstanding-command count; an out-of-range step is a protocol error.
    always_comb begin
        cnt_upd = cnt_q;
        cnt_err = 1'b0;
        if (bus.cmd_issue && !bus.rsp_done) begin
            if (&cnt_q) cnt_err = 1'b1;
            else        cnt_upd = cnt_q + CNT_W'(1);
        end else if (!bus.cmd_issue && bus.rsp_done) begin
            if (cnt_q == '0) cnt_err = 1'b1;
            else             cnt_upd = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_upd;
        drain_tmr_d  = drain_tmr_q;
        hold_tmr_d   = hold_tmr_q;
        rdy_d        = rdy_q;
        ack_n_d      = ack_n_q;
        block_d      = block_q;
        core_rst_n_d = core_rst_n_q;
        drain_to_d   = drain_to_q;
        proto_err_d  = proto_err_q | cnt_err;
        enter_rst    = 1'b0;

        case (state_q)
            RUN: begin
                if (!bus.hs_rst_n) begin
                    enter_rst   = 1'b1;
                    proto_err_d = 1'b1;
                end else if (bus.hs_rst_req) begin
                    state_d     = DRAIN;
                    block_d     = 1'b1;
                    drain_tmr_d = '0;
                end
            end
            DRAIN: begin
                drain_tmr_d = drain_tmr_q + DT_W'(1);
                if (!bus.hs_rst_n) begin
                    enter_rst   = 1'b1;
                    proto_err_d = 1'b1;
                end else if (cnt_upd == '0) begin
                    state_d = READY;
                    rdy_d   = 1'b1;
                end else if (drain_tmr_q == DT_W'(DRAIN_TIMEOUT - 1)) begin
                    state_d    = READY;
                    rdy_d      = 1'b1;
                    drain_to_d = 1'b1;
                end
            end
            READY: begin
                if (!bus.hs_rst_n) enter_rst = 1'b1;
            end
            IN_RST: begin
                hold_tmr_d = hold_tmr_q + HT_W'(1);
                if (hold_tmr_q == HT_W'(RST_HOLD - 1)) begin
                    state_d = ACKED;
                    ack_n_d = 1'b0;
                end
            end
            ACKED: begin
                if (bus.hs_rst_n) begin
                    state_d      = RECOVER;
                    core_rst_n_d = 1'b1;
                end
            end
            RECOVER: begin
                if (bus.cal_done) begin
                    state_d = RUN;
                    ack_n_d = 1'b1;
                    block_d = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase

        // Common entry into reset; in-flight completions are not expected afterwards.
        if (enter_rst) begin
            state_d      = IN_RST;
            block_d      = 1'b1;
            rdy_d        = 1'b0;
            core_rst_n_d = 1'b0;
            hold_tmr_d   = '0;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            drain_tmr_q  <= '0;
            hold_tmr_q   <= '0;
            rdy_q        <= 1'b0;
            ack_n_q      <= 1'b1;
            block_q      <= 1'b0;
            core_rst_n_q <= 1'b1;
            drain_to_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_tmr_q  <= drain_tmr_d;
            hold_tmr_q   <= hold_tmr_d;
            rdy_q        <= rdy_d;
            ack_n_q      <= ack_n_d;
            block_q      <= block_d;
            core_rst_n_q <= core_rst_n_d;
            drain_to_q   <= drain_to_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign bus.hs_rst_rdy    = rdy_q;
    assign bus.hs_rst_ack_n  = ack_n_q;
    assign bus.block_new     = block_q;
    assign bus.core_rst_n    = core_rst_n_q;
    assign bus.drain_timeout = drain_to_q;
    assign bus.proto_err     = proto_err_q;

endmodule

// File: tb/tb_mem_rst_rsp.sv
// Bench for mem_rst_rsp: two configurations share one stimulus stream and are
// compared every cycle against a cycle-level behavioural model of the handshake.
module tb_mem_rst_rsp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0, hsn = 1'b1, issue = 1'b0, done = 1'b0, cal = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;

    always #5 clk = ~clk;

    mem_rst_rsp_if bus_a ();
    mem_rst_rsp_if bus_b ();

    assign bus_a.hs_rst_req = req;
    assign bus_a.hs_rst_n   = hsn;
    assign bus_a.cmd_issue  = issue;
    assign bus_a.rsp_done   = done;
    assign bus_a.cal_done   = cal;
    assign bus_b.hs_rst_req = req;
    assign bus_b.hs_rst_n   = hsn;
    assign bus_b.cmd_issue  = issue;
    assign bus_b.rsp_done   = done;
    assign bus_b.cal_done   = cal;

    mem_rst_rsp #(.CNT_W(8), .DRAIN_TIMEOUT(64), .RST_HOLD(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    mem_rst_rsp #(.CNT_W(2), .DRAIN_TIMEOUT(32), .RST_HOLD(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // Model: phase of the handshake, cycles spent in it, and the true command count.
    localparam int PH_RUN = 0, PH_DRAIN = 1, PH_READY = 2, PH_HOLD = 3, PH_ACKED = 4, PH_RECOVER = 5;
    int m_max[2]  = '{255, 3};
    int m_tmo[2]  = '{64, 32};
    int m_hold[2] = '{5, 3};
    int m_phase[2], m_out[2], m_age[2];
    bit m_rdy[2], m_ack_n[2], m_block[2], m_core_n[2], m_dto[2], m_perr[2];
    string out_name[6] = '{"rdy", "ack_n", "block_new", "core_rst_n", "drain_timeout", "proto_err"};

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = PH_RUN; m_out[i] = 0; m_age[i] = 0;
            m_rdy[i] = 0; m_ack_n[i] = 1; m_block[i] = 0;
            m_core_n[i] = 1; m_dto[i] = 0; m_perr[i] = 0;
        end
    endtask

    task automatic modelStep(input int i);
        int  n;
        bit  go_rst;
        go_rst = 0;
        n = m_out[i] + int'(issue) - int'(done);
        if (n > m_max[i]) begin n = m_max[i]; m_perr[i] = 1; end
        if (n < 0)        begin n = 0;        m_perr[i] = 1; end
        case (m_phase[i])
            PH_RUN:
                if (!hsn) begin go_rst = 1; m_perr[i] = 1; end
                else if (req) begin m_phase[i] = PH_DRAIN; m_block[i] = 1; m_age[i] = 0; end
            PH_DRAIN:
                if (!hsn) begin go_rst = 1; m_perr[i] = 1; end
                else if (n == 0) begin m_phase[i] = PH_READY; m_rdy[i] = 1; end
                else if (m_age[i] + 1 >= m_tmo[i]) begin
                    m_phase[i] = PH_READY; m_rdy[i] = 1; m_dto[i] = 1;
                end else m_age[i]++;
            PH_READY:
                if (!hsn) go_rst = 1;
            PH_HOLD: begin
                m_age[i]++;
                if (m_age[i] == m_hold[i]) begin m_phase[i] = PH_ACKED; m_ack_n[i] = 0; end
            end
            PH_ACKED:
                if (hsn) begin m_phase[i] = PH_RECOVER; m_core_n[i] = 1; end
            default:
                if (cal) begin m_phase[i] = PH_RUN; m_ack_n[i] = 1; m_block[i] = 0; end
        endcase
        if (go_rst) begin
            m_phase[i] = PH_HOLD; m_age[i] = 0; n = 0;
            m_block[i] = 1; m_rdy[i] = 0; m_core_n[i] = 0;
        end
        m_out[i] = n;
    endtask

    always @(posedge clk) begin
        if (!rst_n) modelReset();
        else begin
            modelStep(0);
            modelStep(1);
        end
    end

    function automatic logic [5:0] dutOut(input int i);
        if (i == 0)
            return {bus_a.hs_rst_rdy, bus_a.hs_rst_ack_n, bus_a.block_new,
                    bus_a.core_rst_n, bus_a.drain_timeout, bus_a.proto_err};
        return {bus_b.hs_rst_rdy, bus_b.hs_rst_ack_n, bus_b.block_new,
                bus_b.core_rst_n, bus_b.drain_timeout, bus_b.proto_err};
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [5:0] obs, exp;
                obs = dutOut(i);
                exp = {m_rdy[i], m_ack_n[i], m_block[i], m_core_n[i], m_dto[i], m_perr[i]};
                for (int k = 0; k < 6; k++)
                    checkOutput($sformatf("%s.%s", (i == 0) ? "a" : "b", out_name[k]),
                                obs[5-k], exp[5-k]);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic hn, input logic is,
                                 input logic dn, input logic cl);
        req = r; hsn = hn; issue = is; done = dn; cal = cl;
        @(negedge clk);
    endtask

    task automatic idleSteps(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 1, 0, 0, 0);
    endtask

    task automatic resetDut();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst.rdy",   bus_a.hs_rst_rdy,   1'b0);
        checkOutput("rst.ack_n", bus_a.hs_rst_ack_n, 1'b1);
        checkOutput("rst.block", bus_a.block_new,    1'b0);
        checkOutput("rst.core",  bus_a.core_rst_n,   1'b1);
        checkOutput("rst.perr",  bus_b.proto_err,    1'b0);
        checkOutput("rst.dto",   bus_b.drain_timeout, 1'b0);
        req = 0; hsn = 1; issue = 0; done = 0; cal = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
    endtask

    // Full no-traffic handshake, with timing checked against instance a.
    task automatic idleHandshake();
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("idle.rdy_c1", bus_a.hs_rst_rdy, 1'b0);
        checkOutput("idle.block",  bus_a.block_new,  1'b1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("idle.rdy_c2", bus_a.hs_rst_rdy, 1'b1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idle.core_low", bus_a.core_rst_n, 1'b0);
        checkOutput("idle.rdy_drop", bus_a.hs_rst_rdy, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idle.ack_early", bus_a.hs_rst_ack_n, 1'b1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idle.ack", bus_a.hs_rst_ack_n, 1'b0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("idle.core_high", bus_a.core_rst_n, 1'b1);
        checkOutput("idle.ack_held",  bus_a.hs_rst_ack_n, 1'b0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("idle.ack_rel",   bus_a.hs_rst_ack_n, 1'b1);
        checkOutput("idle.unblock",   bus_a.block_new, 1'b0);
        checkOutput("idle.perr",      bus_a.proto_err, 1'b0);
        idleSteps(2);
    endtask

    task automatic finishHandshake();
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1);
        idleSteps(1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        @(negedge clk);
        resetDut();
        idleHandshake();

        // Drain with traffic
        resetDut();
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            idleSteps(9);
            applyStimulus(0, 1, 0, 1, 0);
        end
        applyStimulus(0, 1, 1, 1, 0);
        idleSteps(4);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("drain.rdy_early", bus_a.hs_rst_rdy, 1'b0);
        idleSteps(4);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("drain.rdy",   bus_a.hs_rst_rdy,    1'b1);
        checkOutput("drain.dto",   bus_a.drain_timeout, 1'b0);
        checkOutput("drain.block", bus_a.block_new,     1'b1);
        finishHandshake();

        // Drain timeout on instance b
        resetDut();
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        idleSteps(31);
        checkOutput("tmo.rdy_early", bus_b.hs_rst_rdy, 1'b0);
        idleSteps(1);
        checkOutput("tmo.rdy", bus_b.hs_rst_rdy,    1'b1);
        checkOutput("tmo.dto", bus_b.drain_timeout, 1'b1);
        checkOutput("tmo.a_waiting", bus_a.hs_rst_rdy, 1'b0);
        finishHandshake();
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("tmo.cnt_cleared", bus_b.hs_rst_rdy, 1'b1);
        finishHandshake();

        // Underflow and early warm reset
        resetDut();
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("err.underflow", bus_a.proto_err, 1'b1);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("err.cnt_zero", bus_a.hs_rst_rdy, 1'b1);
        finishHandshake();
        resetDut();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("err.run_rst_perr",  bus_a.proto_err,  1'b1);
        checkOutput("err.run_rst_core",  bus_a.core_rst_n, 1'b0);
        checkOutput("err.run_rst_block", bus_a.block_new,  1'b1);
        finishHandshake();

        // Asynchronous reset while acknowledged
        resetDut();
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mid.acked", bus_a.hs_rst_ack_n, 1'b0);
        resetDut();
        idleHandshake();

        // Counter saturation on instance b
        resetDut();
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 1, 0, 0);
        checkOutput("sat.b_perr", bus_b.proto_err, 1'b1);
        checkOutput("sat.a_perr", bus_a.proto_err, 1'b0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("sat.rdy_early", bus_b.hs_rst_rdy, 1'b0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("sat.rdy", bus_b.hs_rst_rdy, 1'b1);
        checkOutput("sat.dto", bus_b.drain_timeout, 1'b0);
        finishHandshake();

        // Random traffic and handshake activity
        resetDut();
        for (int k = 0; k < 600; k++)
            applyStimulus(logic'($urandom_range(0, 5) == 0),
                          logic'($urandom_range(0, 9) != 0),
                          logic'($urandom_range(0, 2) == 0),
                          logic'($urandom_range(0, 2) == 0),
                          logic'($urandom_range(0, 3) == 0));

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
